// File: rtl/fifo_rd_arbiter.sv
// Round-robin read-port scheduler for an async FIFO: grants bursts to NREQ
// consumers, gates the FIFO pop, tags data with the grantee ID, aborts starved bursts.
module fifo_rd_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int LENW  = 4,
  parameter int DSIZE = 8,
  parameter int TMO   = 16
) (
  input  logic                 rclk_i,
  input  logic                 rrst_n_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*LENW-1:0] req_len_i,
  output logic [NREQ-1:0]      grant_o,
  input  logic                 rd_ready_i,
  input  logic                 fifo_empty_i,
  input  logic [DSIZE-1:0]     fifo_rdata_i,
  output logic                 ren_o,
  output logic                 rd_valid_o,
  output logic [DSIZE-1:0]     rd_data_o,
  output logic [IDW-1:0]       rd_id_o,
  output logic                 done_o,
  output logic                 abort_o,
  output logic                 busy_o,
  output logic [1:0]           dbg_state_o
);

  // Handshake: a word moves to the granted consumer in any BURST cycle where the
  // FIFO is non-empty and rd_ready_i is high; that same cycle pops the FIFO
  // (ren_o) and flags the word (rd_valid_o). There is no other transfer path.

  localparam int TW = (TMO < 1) ? 1 : $clog2(TMO + 1);
  localparam logic [TW-1:0] TMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_last;
  logic [IDW-1:0]    r_id;
  logic [NREQ-1:0]   r_grant;
  logic [LENW-1:0]   r_remain;
  logic [TW-1:0]     r_tmo;
  logic              r_done;
  logic              r_abort;

  logic              w_found;
  logic [IDW-1:0]    w_pick;
  logic [LENW-1:0]   w_len;
  logic              w_ren;
  logic [TW-1:0]     w_tmo_nxt;
  logic              w_tmo_hit;

  // Search from last+1 upward; IDW-bit addition gives the modulo-NREQ wrap.
  always_comb begin
    logic [IDW-1:0] v_idx;
    w_found = 1'b0;
    w_pick  = '0;
    v_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      v_idx = r_last + IDW'(i);
      if (!w_found && req_i[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end
    end
  end

  assign w_len     = req_len_i[int'(w_pick)*LENW +: LENW];
  assign w_ren     = (r_state == S_BURST) & ~fifo_empty_i & rd_ready_i;
  assign w_tmo_nxt = (r_tmo == TMAX) ? r_tmo : r_tmo + 1'b1;
  assign w_tmo_hit = (TMO != 0) && fifo_empty_i && (w_tmo_nxt == TW'(TMO));

  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      r_state  <= S_IDLE;
      r_last   <= IDW'(NREQ - 1);
      r_id     <= '0;
      r_grant  <= '0;
      r_remain <= '0;
      r_tmo    <= '0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant  <= NREQ'(1) << w_pick;
            r_id     <= w_pick;
            r_remain <= w_len;
            r_tmo    <= '0;
            r_last   <= w_pick;
            r_state  <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_ren) begin
            if (r_remain == '0) begin
              r_done  <= 1'b1;
              r_abort <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_remain <= r_remain - 1'b1;
            end
          end
          // Only empty cycles age the burst; consumer stalls never do.
          if (fifo_empty_i) begin
            r_tmo <= w_tmo_nxt;
            if (w_tmo_hit) begin
              r_done  <= 1'b1;
              r_abort <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_tmo <= '0;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_abort <= 1'b0;
          r_grant <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ren_o       = w_ren;
  assign rd_valid_o  = w_ren;
  assign rd_data_o   = fifo_rdata_i;
  assign rd_id_o     = r_id;
  assign grant_o     = r_grant;
  assign done_o      = r_done;
  assign abort_o     = r_abort;
  assign busy_o      = (r_state != S_IDLE);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a small behavioural FIFO feeding the read port.
module tb_fifo_rd_arbiter;

  localparam int NREQ = 4, IDW = 2, LENW = 4, DSIZE = 8, TMO = 16;

  logic                 rclk = 1'b0;
  logic                 rrst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*LENW-1:0] req_len = '0;
  logic [NREQ-1:0]      grant_o;
  logic                 rd_ready = 1'b0;
  logic                 fifo_empty;
  logic [DSIZE-1:0]     fifo_rdata;
  logic                 ren_o, rd_valid_o, done_o, abort_o, busy_o;
  logic [DSIZE-1:0]     rd_data_o;
  logic [IDW-1:0]       rd_id_o;
  logic [1:0]           dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model: registered pointers, so empty behaves like a registered flag
  logic [7:0] mem [0:63];
  logic [6:0] wp = '0, rp = '0;
  logic       push_en = 1'b0, fifo_clr = 1'b0;
  logic [7:0] push_data = '0;

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (fifo_clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_en) begin
        mem[wp[5:0]] <= push_data;
        wp <= wp + 7'd1;
      end
      if (ren_o) rp <= rp + 7'd1;
    end
  end

  assign fifo_empty = (wp == rp);
  assign fifo_rdata = mem[rp[5:0]];

  fifo_rd_arbiter #(.NREQ(NREQ), .IDW(IDW), .LENW(LENW), .DSIZE(DSIZE), .TMO(TMO)) dut (
    .rclk_i(rclk), .rrst_n_i(rrst_n), .req_i(req), .req_len_i(req_len),
    .grant_o(grant_o), .rd_ready_i(rd_ready), .fifo_empty_i(fifo_empty),
    .fifo_rdata_i(fifo_rdata), .ren_o(ren_o), .rd_valid_o(rd_valid_o),
    .rd_data_o(rd_data_o), .rd_id_o(rd_id_o), .done_o(done_o), .abort_o(abort_o),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      push_data = base + 8'(i);
      push_en   = 1'b1;
      tick();
    end
    push_en = 1'b0;
  endtask

  task automatic do_reset();
    rrst_n = 1'b0; fifo_clr = 1'b1; req = '0; req_len = '0; rd_ready = 1'b0;
    tick(); tick();
    rrst_n = 1'b1; fifo_clr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rrst_n = 1'b0; fifo_clr = 1'b1;
    tick(); tick();
    n_cmp++; if (grant_o !== 4'b0000) begin n_err++; $display("FAIL rst_grant: got %b want 0000", grant_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_cmp++; if (ren_o !== 1'b0 || rd_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_ren: got %b/%b want 0/0", ren_o, rd_valid_o); end
    n_cmp++; if (done_o !== 1'b0 || abort_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b/%b want 0/0", done_o, abort_o); end
    n_cmp++; if (rd_id_o !== 2'd0) begin n_err++; $display("FAIL rst_id: got %0d want 0", rd_id_o); end
    n_cmp++; if (dbg_state_o !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state_o); end
    rrst_n = 1'b1; fifo_clr = 1'b0;
    #1;
  endtask

  task automatic test_single_burst();
    fill(4, 8'hA0);
    req = 4'b0001; req_len = 16'h0003; rd_ready = 1'b1;
    #1;
    n_cmp++; if (ren_o !== 1'b0) begin n_err++; $display("FAIL single_idle_ren: got %b want 0", ren_o); end
    tick();
    req = '0;
    n_cmp++; if (grant_o !== 4'b0001 || rd_id_o !== 2'd0) begin n_err++; $display("FAIL single_grant: got %b/%0d want 0001/0", grant_o, rd_id_o); end
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (rd_valid_o !== 1'b1 || rd_data_o !== 8'hA0 + 8'(i) || rd_id_o !== 2'd0) begin
        n_err++; $display("FAIL single_pop%0d: got v=%b d=%h id=%0d want v=1 d=%h id=0", i, rd_valid_o, rd_data_o, rd_id_o, 8'hA0 + 8'(i));
      end
      tick();
    end
    n_cmp++; if (done_o !== 1'b1 || abort_o !== 1'b0) begin n_err++; $display("FAIL single_done: got %b/%b want 1/0", done_o, abort_o); end
    n_cmp++; if (grant_o !== 4'b0001 || ren_o !== 1'b0 || busy_o !== 1'b1) begin n_err++; $display("FAIL single_done_hold: got g=%b ren=%b busy=%b want 0001/0/1", grant_o, ren_o, busy_o); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b want 1", fifo_empty); end
    tick();
    n_cmp++; if (grant_o !== 4'b0000 || done_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL single_idle: got g=%b done=%b busy=%b want 0000/0/0", grant_o, done_o, busy_o); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    fill(5, 8'h10);
    req = 4'b1111; req_len = 16'h0000; rd_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      tick();
      exp_g = 4'b0001 << (g % 4);
      #1;
      n_cmp++;
      if (grant_o !== exp_g || rd_id_o !== 2'(g % 4) || ren_o !== 1'b1 || rd_data_o !== 8'h10 + 8'(g)) begin
        n_err++; $display("FAIL rr_grant%0d: got g=%b id=%0d ren=%b d=%h want %b/%0d/1/%h", g, grant_o, rd_id_o, ren_o, rd_data_o, exp_g, g % 4, 8'h10 + 8'(g));
      end
      tick();
      if (g == 4) req = '0;
      #1;
      n_cmp++; if (done_o !== 1'b1 || ren_o !== 1'b0) begin n_err++; $display("FAIL rr_done%0d: got done=%b ren=%b want 1/0", g, done_o, ren_o); end
      tick();
      #1;
      n_cmp++; if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin n_err++; $display("FAIL rr_idle%0d: got busy=%b g=%b want 0/0000", g, busy_o, grant_o); end
    end
    tick();
    n_cmp++; if (busy_o !== 1'b0 || fifo_empty !== 1'b1) begin n_err++; $display("FAIL rr_end: got busy=%b empty=%b want 0/1", busy_o, fifo_empty); end
  endtask

  task automatic test_backpressure();
    logic [4:0] pat;
    int pops;
    pat = 5'b11001;  // bit i = ready in BURST cycle i: 1,0,0,1,1
    pops = 0;
    do_reset();
    fill(3, 8'h30);
    req = 4'b0001; req_len = 16'h0002; rd_ready = 1'b0;
    tick();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      rd_ready = pat[i];
      #1;
      n_cmp++; if (ren_o !== pat[i]) begin n_err++; $display("FAIL bp_ren%0d: got %b want %b", i, ren_o, pat[i]); end
      if (ren_o === 1'b1) pops++;
      tick();
    end
    n_cmp++; if (pops !== 3) begin n_err++; $display("FAIL bp_pops: got %0d want 3", pops); end
    n_cmp++; if (done_o !== 1'b1 || abort_o !== 1'b0) begin n_err++; $display("FAIL bp_done: got %b/%b want 1/0", done_o, abort_o); end
    tick();
    rd_ready = 1'b1;
  endtask

  task automatic test_starvation();
    int bad;
    bad = 0;
    do_reset();
    fill(2, 8'h50);
    req = 4'b0001; req_len = 16'h0007; rd_ready = 1'b1;
    tick();
    req = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (ren_o !== 1'b1 || rd_data_o !== 8'h50 + 8'(i)) begin n_err++; $display("FAIL starve_pop%0d: got ren=%b d=%h want 1/%h", i, ren_o, rd_data_o, 8'h50 + 8'(i)); end
      tick();
    end
    for (int i = 0; i < TMO; i++) begin
      #1;
      if (ren_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1) bad++;
      tick();
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL starve_wait: got %0d bad cycles want 0", bad); end
    n_cmp++; if (done_o !== 1'b1 || abort_o !== 1'b1) begin n_err++; $display("FAIL starve_abort: got %b/%b want 1/1", done_o, abort_o); end
    tick();
    n_cmp++; if (busy_o !== 1'b0 || abort_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL starve_idle: got busy=%b abort=%b done=%b want 0/0/0", busy_o, abort_o, done_o); end
  endtask

  task automatic test_refill();
    int bad;
    bad = 0;
    do_reset();
    fill(1, 8'h70);
    req = 4'b0001; req_len = 16'h0003; rd_ready = 1'b1;
    tick();
    req = '0;
    #1;
    n_cmp++; if (ren_o !== 1'b1) begin n_err++; $display("FAIL refill_first: got %b want 1", ren_o); end
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 10; e++) begin
        #1;
        if (ren_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1) bad++;
        if (e == 9) begin push_en = 1'b1; push_data = 8'h71 + 8'(r); end
        tick();
        push_en = 1'b0;
      end
      #1;
      n_cmp++; if (ren_o !== 1'b1 || rd_data_o !== 8'h71 + 8'(r)) begin n_err++; $display("FAIL refill_pop%0d: got ren=%b d=%h want 1/%h", r, ren_o, rd_data_o, 8'h71 + 8'(r)); end
      tick();
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL refill_wait: got %0d bad cycles want 0", bad); end
    n_cmp++; if (done_o !== 1'b1 || abort_o !== 1'b0) begin n_err++; $display("FAIL refill_done: got %b/%b want 1/0", done_o, abort_o); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    fill(8, 8'h90);
    req = 4'b0010; req_len = 16'h0070; rd_ready = 1'b1;
    tick();
    req = '0;
    n_cmp++; if (grant_o !== 4'b0010 || rd_id_o !== 2'd1) begin n_err++; $display("FAIL mid_grant: got %b/%0d want 0010/1", grant_o, rd_id_o); end
    tick(); tick();
    #1;
    n_cmp++; if (ren_o !== 1'b1) begin n_err++; $display("FAIL mid_third_pop: got %b want 1", ren_o); end
    rrst_n = 1'b0;
    #1;
    n_cmp++; if (ren_o !== 1'b0 || grant_o !== 4'b0000 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got ren=%b g=%b busy=%b done=%b want 0/0000/0/0", ren_o, grant_o, busy_o, done_o);
    end
    tick();
    rrst_n = 1'b1;
    req = 4'b0011; req_len = 16'h0000;
    tick();
    req = '0;
    #1;
    n_cmp++; if (grant_o !== 4'b0001 || rd_id_o !== 2'd0 || ren_o !== 1'b1 || rd_data_o !== 8'h92) begin
      n_err++; $display("FAIL mid_after: got g=%b id=%0d ren=%b d=%h want 0001/0/1/92", grant_o, rd_id_o, ren_o, rd_data_o);
    end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_starvation();
    test_refill();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
